fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch stage directly upstream of the immediate extender and decode.
- Holds the PC and fetches 32-bit instructions from instruction memory with a req/ack handshake.
- Presents each instruction to decode with a valid/ready handshake.
- Consumes the extender's 64-bit branch offset plus branch control from execute to select the next PC (PC+4 or PC+offset).

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until acknowledged.
- imem_addr  output  64  byte address of the fetch; always equals PC.
- imem_ack  input  1  memory accepts the request and returns data this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- inst_valid  output  1  Instruction/CurPC hold a fetched instruction.
- inst_ready  input  1  decode/execute consumes the instruction this cycle.
- Instruction  output  32  buffered instruction word; decode slices [25:0] to the extender.
- CurPC  output  64  PC of the presented instruction.
- BranchOffset  input  64  extender output, already sign-extended and shifted left by 2.
- UncondBranch  input  1  B-type instruction.
- Branch  input  1  CB-type instruction.
- Zero  input  1  ALU zero flag for CBZ.
- fetch_fault  output  1  sticky watchdog flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- States: REQ, ISSUE, encoded 1 bit.
- Reset cycle (Reset=1):
  - PC<=RESET_PC, Instruction<=32'h0, state<=REQ, fetch_fault<=0.
  - imem_req and inst_valid forced 0 combinationally while Reset=1.
- REQ:
  - imem_req=1, imem_addr=PC, inst_valid=0.
  - If imem_ack=1: Instruction<=imem_rdata, state<=ISSUE. A zero-wait ack in the first REQ cycle is legal.
  - If imem_ack=0: stay in REQ; PC and address stay stable.
- ISSUE:
  - imem_req=0, inst_valid=1, Instruction and CurPC stable.
  - imem_ack in ISSUE is ignored.
  - If inst_ready=1: PC<=NextPC, state<=REQ.
  - If inst_ready=0: hold indefinitely (stall).
- Branch sampling: branch inputs are sampled only in the cycle ISSUE and inst_ready are both high.
  - taken = UncondBranch | (Branch & Zero).
  - NextPC = taken ? PC + BranchOffset : PC + 64'd4.
  - 64-bit modulo add: wrap-around at 2^64 is silent, with no flag.
  - NextPC[1:0] forced to 2'b00 (alignment guard).
- Timing:
  - Latency from request to inst_valid: 1 cycle after the ack edge.
  - Peak throughput: one instruction per 2 cycles.
- CurPC is a registered copy of PC captured with Instruction, so it equals imem_addr of that fetch.
- Reset asserted in any state, including mid-wait or mid-stall: the outstanding request is abandoned. An ack that arrives in the cycle Reset is high is discarded.
- Simultaneous Reset and inst_ready: Reset wins.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ and clears on ack or on state change.
  - If it reaches TIMEOUT_CYCLES with no ack: fetch_fault<=1 (sticky until Reset), the counter clears, and REQ continues with the same address.
- Undefined: no counter is built and fetch_fault is tied 0.

Decomposition:
- Package fetch_pkg holds:
  - state typedef (REQ, ISSUE);
  - INST_BYTES=64'd4;
  - PC_ALIGN_MASK=~64'h3.
  - SignOp encodings stay in the shared define set.
- One sub-module, next_pc_calc: purely combinational taken/NextPC mux and adders. The PC register stays in fetch_sequencer.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), inst_ready=1, no branches -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid high every other cycle; Instruction matches imem_rdata.
- Memory ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr constant; inst_valid rises the cycle after ack.
- inst_ready held 0 for 5 ISSUE cycles -> Instruction/CurPC stable, imem_req=0; PC advances only after inst_ready=1.
- At PC=0x100:
  - UncondBranch=1, BranchOffset=64'hFFFF_FFFF_FFFF_FFF0 -> next fetch at 0xF0.
  - Branch=1, Zero=0, offset 0x40 -> next fetch at 0x104.
  - Branch=1, Zero=1, offset 0x40 -> next fetch at 0x140.
- Reset pulsed during a stalled ISSUE and during a pending REQ -> next request at RESET_PC; a late ack in the reset cycle is not captured.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack withheld 6 cycles -> fetch_fault=1 from cycle 4 onward, imem_req still high; the subsequent ack completes normally and fetch_fault stays 1 until Reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

  typedef enum logic {
    REQ   = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  localparam logic [63:0] INST_BYTES    = 64'd4;
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational branch resolution and next-PC selection
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [63:0] pc_i,
  input  logic [63:0] branch_offset_i,
  input  logic        uncond_branch_i,
  input  logic        branch_i,
  input  logic        zero_i,
  output logic [63:0] next_pc_o
);

  logic        taken;
  logic [63:0] target;

  assign taken  = uncond_branch_i | (branch_i & zero_i);
  // Both adds wrap modulo 2^64; the low bits are cleared so a bad offset cannot misalign fetch.
  assign target = taken ? (pc_i + branch_offset_i) : (pc_i + INST_BYTES);
  assign next_pc_o = target & PC_ALIGN_MASK;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register and imem/decode handshakes; FETCH_TIMEOUT_EN adds a fetch watchdog
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Instruction,
  output logic [63:0] CurPC,
  input  logic [63:0] BranchOffset,
  input  logic        UncondBranch,
  input  logic        Branch,
  input  logic        Zero,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d, cur_pc_q, next_pc;
  logic [31:0]  inst_q;
  logic         capture, advance;

  assign capture = (state_q == REQ) & imem_ack;
  assign advance = (state_q == ISSUE) & inst_ready;

  next_pc_calc u_next_pc (
    .pc_i            (pc_q),
    .branch_offset_i (BranchOffset),
    .uncond_branch_i (UncondBranch),
    .branch_i        (Branch),
    .zero_i          (Zero),
    .next_pc_o       (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     if (imem_ack)   state_d = ISSUE;
      ISSUE:   if (inst_ready) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  // Handshake outputs are gated by Reset so nothing leaks out during the reset cycle.
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    if (!Reset) begin
      imem_req   = (state_q == REQ);
      inst_valid = (state_q == ISSUE);
    end
  end

  assign pc_d = advance ? next_pc : pc_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0;
      cur_pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (capture) begin
        inst_q   <= imem_rdata;
        cur_pc_q <= pc_q;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign Instruction = inst_q;
  assign CurPC       = cur_pc_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;

  always_comb begin
    wait_cnt_d = '0;
    fault_d    = fault_q;
    if ((state_q == REQ) && !imem_ack) begin
      if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) fault_d = 1'b1;
      else                                          wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule
